// File: rtl/axis_uart_tx.sv
// axis_uart_tx: byte-stream 8N1 UART transmitter with optional line terminator.
//
// Accepts 8-bit AXI-Stream-style beats and serialises each one as a single
// 8N1 frame, LSB first. When a beat carries tlast and APPEND_NL is set, an
// extra NL_CHAR frame follows right after it, so that each packet appears as
// one line on a terminal.
//
// Parameters:
//   CLK_FREQ_HZ  i_clk frequency in Hz
//   BAUD         serial bit rate; bit period DIV = CLK_FREQ_HZ / BAUD (>= 2)
//   APPEND_NL    1: send NL_CHAR after every byte accepted with tlast
//   NL_CHAR      line terminator byte
//
// Ports:
//   i_clk      core clock, rising edge
//   i_rst_n    asynchronous active-low reset (release synchronised inside)
//   i_tdata    stream byte
//   i_tlast    last byte of packet
//   i_tvalid   byte valid
//   o_tready   registered; high only while idle
//   o_uart_tx  serial output, idles high
//   o_busy     registered; high while a frame or pending terminator is active
module axis_uart_tx #(
    parameter int unsigned CLK_FREQ_HZ = 32000000,
    parameter int unsigned BAUD        = 57600,
    parameter int unsigned APPEND_NL   = 1,
    parameter logic [7:0]  NL_CHAR     = 8'h0A
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_tdata,
    input  logic       i_tlast,
    input  logic       i_tvalid,
    output logic       o_tready,
    output logic       o_uart_tx,
    output logic       o_busy
);

    localparam int unsigned DIV = CLK_FREQ_HZ / BAUD;
    localparam int unsigned CW  = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("axis_uart_tx: CLK_FREQ_HZ/BAUD must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // Reset asserts immediately but is released two edges later, so the
    // main registers never see a release close to a clock edge.
    logic [1:0] rst_sync;
    logic       rst_int_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    state_t          state, state_n;
    logic [CW-1:0]   baud, baud_n;
    logic [2:0]      bitc, bit_n;
    logic [7:0]      shreg, shreg_n;
    logic            nl_pending, nl_n;
    logic            tx_n;
    logic            baud_done;

    always_ff @(posedge i_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state      <= IDLE;
            baud       <= '0;
            bitc       <= '0;
            shreg      <= '0;
            nl_pending <= 1'b0;
            o_uart_tx  <= 1'b1;
            o_tready   <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            state      <= state_n;
            baud       <= baud_n;
            bitc       <= bit_n;
            shreg      <= shreg_n;
            nl_pending <= nl_n;
            // Outputs are registered from the next-state values, so the
            // start bit appears on the cycle right after the transfer edge.
            o_uart_tx  <= tx_n;
            o_tready   <= (state_n == IDLE);
            o_busy     <= (state_n != IDLE);
        end
    end

    always_comb begin
        state_n   = state;
        baud_n    = baud;
        bit_n     = bitc;
        shreg_n   = shreg;
        nl_n      = nl_pending;
        tx_n      = 1'b1;
        baud_done = (baud == BAUD_LAST);

        case (state)
            IDLE: begin
                if (i_tvalid && o_tready) begin
                    state_n = START;
                    shreg_n = i_tdata;
                    nl_n    = (APPEND_NL != 0) && i_tlast;
                    baud_n  = '0;
                    bit_n   = '0;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_n  = '0;
                    state_n = DATA;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_n  = '0;
                    shreg_n = {1'b0, shreg[7:1]};
                    if (bitc == 3'd7) begin
                        bit_n   = '0;
                        state_n = STOP;
                    end else begin
                        bit_n = bitc + 3'd1;
                    end
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_n = '0;
                    if (nl_pending) begin
                        // Terminator frame chains straight into a new start
                        // bit; it cannot re-arm nl_pending itself.
                        nl_n    = 1'b0;
                        shreg_n = NL_CHAR;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shreg_n[0];
            default: tx_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_axis_uart_tx.sv
// tb_axis_uart_tx: self-checking bench for axis_uart_tx at DIV=10.
// Two instances: dut_a with the line terminator enabled, dut_b without it.
module tb_axis_uart_tx;

    localparam int DIV = 10;  // 1000 Hz / 100 baud

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tdata = '0;
    logic       tlast = 1'b0;
    logic       tvalid_a = 1'b0;
    logic       tvalid_b = 1'b0;
    logic       ready_a, tx_a, busy_a;
    logic       ready_b, tx_b, busy_b;

    bit         sel = 1'b0;  // 0: observe dut_a, 1: observe dut_b
    logic       tx_m, ready_m, busy_m;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_q[$];

    always #5 clk = ~clk;

    axis_uart_tx #(
        .CLK_FREQ_HZ(1000),
        .BAUD(100),
        .APPEND_NL(1),
        .NL_CHAR(8'h0A)
    ) dut_a (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_tdata(tdata),
        .i_tlast(tlast),
        .i_tvalid(tvalid_a),
        .o_tready(ready_a),
        .o_uart_tx(tx_a),
        .o_busy(busy_a)
    );

    axis_uart_tx #(
        .CLK_FREQ_HZ(1000),
        .BAUD(100),
        .APPEND_NL(0),
        .NL_CHAR(8'h0A)
    ) dut_b (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_tdata(tdata),
        .i_tlast(tlast),
        .i_tvalid(tvalid_b),
        .o_tready(ready_b),
        .o_uart_tx(tx_b),
        .o_busy(busy_b)
    );

    assign tx_m    = sel ? tx_b    : tx_a;
    assign ready_m = sel ? ready_b : ready_a;
    assign busy_m  = sel ? busy_b  : busy_a;

    // Record the cycle number of every transfer into dut_a.
    always @(posedge clk) begin
        if (tvalid_a === 1'b1 && ready_a === 1'b1) acc_q.push_back(cyc);
        cyc = cyc + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait for ready, present one beat, return at the negedge after the
    // transfer edge (frame cycle 0). Unless keep_valid, the beat is withdrawn
    // and the data lines are scrambled.
    task automatic send(input logic [7:0] b, input bit last, input bit keep_valid);
        int w = 0;
        while (ready_m !== 1'b1 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 1000) check("ready_timeout", w, 0);
        tdata = b;
        tlast = last;
        if (sel) tvalid_b = 1'b1; else tvalid_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!keep_valid) begin
            tvalid_a = 1'b0;
            tvalid_b = 1'b0;
            tdata = 8'($urandom);
            tlast = 1'($urandom);
        end
    endtask

    // Reference: each frame is start(0), 8 data bits LSB first, stop(1), each
    // held DIV cycles; frames chain with no gap; ready returns right after.
    task automatic expect_frames(input logic [7:0] b, input bit nl);
        logic [7:0] fb [2];
        logic [7:0] dec [2];
        logic       expb;
        int nf, n, k, f, j;
        int mism = 0, rdy_hi = 0, not_busy = 0;
        fb[0] = b;
        fb[1] = 8'h0A;
        dec[0] = '0;
        dec[1] = '0;
        nf = nl ? 2 : 1;
        n = nf * 10 * DIV;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            k = i / DIV;
            f = k / 10;
            j = k % 10;
            if (j == 0) expb = 1'b0;
            else if (j == 9) expb = 1'b1;
            else expb = fb[f][j-1];
            if (tx_m !== expb) mism++;
            if (ready_m !== 1'b0) rdy_hi++;
            if (busy_m !== 1'b1) not_busy++;
            if ((i % DIV) == DIV / 2 && j >= 1 && j <= 8) dec[f][j-1] = tx_m;
        end
        for (int g = 0; g < nf; g++) check($sformatf("decode%0d", g), dec[g], fb[g]);
        check("tx_wave_mismatches", mism, 0);
        check("tready_low_cycles", rdy_hi, 0);
        check("busy_high_cycles", not_busy, 0);
        @(negedge clk);
        check("tready_back", ready_m, 1);
        check("tx_idle_after", tx_m, 1);
        check("busy_clear", busy_m, 0);
    endtask

    initial begin
        int edges, txlow, busyhi;
        logic [7:0] rb;
        bit rl;

        // Reset with valid asserted
        tvalid_a = 1'b1;
        tvalid_b = 1'b1;
        tdata = 8'h99;
        repeat (4) @(negedge clk);
        check("rst_tx", tx_a, 1);
        check("rst_tready", ready_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_tready_b", ready_b, 0);
        rst_n = 1'b1;
        edges = 0;
        txlow = 0;
        while (ready_a !== 1'b1 && edges < 10) begin
            @(negedge clk);
            edges++;
            if (tx_a !== 1'b1) txlow++;
        end
        tvalid_a = 1'b0;
        tvalid_b = 1'b0;
        check("ready_within_3", (edges <= 3), 1);
        check("no_early_frame", txlow, 0);
        check("ready_b_up", ready_b, 1);
        @(negedge clk);
        check("no_transfer_in_reset", acc_q.size(), 0);
        check("idle_tx_after_rst", tx_a, 1);

        // 0x55, no tlast
        sel = 1'b0;
        send(8'h55, 1'b0, 1'b0);
        expect_frames(8'h55, 1'b0);

        // 0x41 with tlast: chained terminator
        send(8'h41, 1'b1, 1'b0);
        expect_frames(8'h41, 1'b1);

        // Back-to-back with valid held high
        send(8'h00, 1'b0, 1'b1);
        tdata = 8'hFF;
        tlast = 1'b0;
        expect_frames(8'h00, 1'b0);
        @(posedge clk);
        @(negedge clk);
        tvalid_a = 1'b0;
        expect_frames(8'hFF, 1'b0);
        check("b2b_spacing", acc_q[acc_q.size()-1] - acc_q[acc_q.size()-2], 101);

        // Reset during data bit 3 of 0xA5 (tlast set)
        send(8'hA5, 1'b1, 1'b0);
        repeat (45) @(negedge clk);
        check("pre_rst_bit3", tx_a, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_tx", tx_a, 1);
        check("rst_async_busy", busy_a, 0);
        check("rst_async_tready", ready_a, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        txlow = 0;
        busyhi = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx_a !== 1'b1) txlow++;
            if (busy_a !== 1'b0) busyhi++;
        end
        check("no_resend_after_rst", txlow, 0);
        check("idle_after_rst", busyhi, 0);
        check("ready_after_rst", ready_a, 1);
        send(8'h3C, 1'b0, 1'b0);
        expect_frames(8'h3C, 1'b0);

        // Randomized beats into dut_a
        repeat (6) begin
            rb = 8'($urandom);
            rl = 1'($urandom);
            send(rb, rl, 1'b0);
            expect_frames(rb, rl);
        end

        // Terminator disabled
        sel = 1'b1;
        send(8'h7E, 1'b1, 1'b0);
        expect_frames(8'h7E, 1'b0);
        repeat (3) begin
            rb = 8'($urandom);
            rl = 1'($urandom);
            send(rb, rl, 1'b0);
            expect_frames(rb, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
